// File: rtl/pll_freq_controller.sv
// DCO frequency-lock controller: counts DCO cycles per reference period, steps a thermometer trim, flags lock.
// Optional measurement outputs (meas_count, meas_valid) are enabled by defining PLL_FREQ_CONTROLLER_MEAS_EN.
`timescale 1ns/1ps
module pll_freq_controller #(
    parameter int DIV_W     = 5,
    parameter int CNT_W     = 7,
    parameter int TRIM_W    = 26,
    parameter int TRIM_INIT = 0,
    parameter int LOCK_CNT  = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              enable,
    input  logic              ref_clk,
    input  logic [DIV_W-1:0]  div,
    output logic [TRIM_W-1:0] trim,
`ifdef PLL_FREQ_CONTROLLER_MEAS_EN
    output logic [CNT_W-1:0]  meas_count,
    output logic              meas_valid,
`endif
    output logic              lock
);

    localparam int LVL_W = $clog2(TRIM_W + 1);
    localparam int LC_W  = $clog2(LOCK_CNT + 1);
    localparam int CMP_W = ((CNT_W > DIV_W) ? CNT_W : DIV_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(TRIM_W);
    localparam logic [LVL_W-1:0] LVL_INIT = LVL_W'(TRIM_INIT);
    localparam logic [LC_W-1:0]  LC_MAX   = LC_W'(LOCK_CNT);

    logic [2:0]       ref_s;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             first_seen, first_seen_n;
    logic [LC_W-1:0]  lc, lc_n;
    logic [LVL_W-1:0] level, level_n;
    logic             lock_n;
    logic             rise, timeout, valid;
    logic [CMP_W-1:0] c_ext, d_ext;
    logic             near;

    assign rise    = ref_s[1] & ~ref_s[2];
    assign timeout = (cnt == CNT_MAX);
    assign valid   = enable & rise & first_seen;
    assign c_ext   = CMP_W'(cnt);
    assign d_ext   = CMP_W'(div);
    assign near    = (c_ext == d_ext) || (c_ext == d_ext + CMP_W'(1)) || (d_ext == c_ext + CMP_W'(1));

    always_comb begin
        cnt_n        = cnt;
        first_seen_n = first_seen;
        lc_n         = lc;
        level_n      = level;
        if (!enable) begin
            cnt_n        = '0;
            first_seen_n = 1'b0;
            lc_n         = '0;
        end else if (rise) begin
            // a rise on the saturated count still measures, so it takes priority over timeout
            cnt_n        = CNT_W'(1);
            first_seen_n = 1'b1;
            if (first_seen) begin
                if (div == '0) begin
                    lc_n = '0;
                end else begin
                    if (c_ext > d_ext && level != LVL_MAX)
                        level_n = level + LVL_W'(1);
                    else if (c_ext < d_ext && level != '0)
                        level_n = level - LVL_W'(1);
                    if (!near)
                        lc_n = '0;
                    else if (lc != LC_MAX)
                        lc_n = lc + LC_W'(1);
                end
            end
        end else if (timeout) begin
            first_seen_n = 1'b0;
            lc_n         = '0;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
        lock_n = (lc_n == LC_MAX);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ref_s      <= 3'b000;
            cnt        <= '0;
            first_seen <= 1'b0;
            lc         <= '0;
            lock       <= 1'b0;
            level      <= LVL_INIT;
        end else begin
            ref_s      <= {ref_s[1:0], ref_clk};
            cnt        <= cnt_n;
            first_seen <= first_seen_n;
            lc         <= lc_n;
            lock       <= lock_n;
            level      <= level_n;
        end
    end

    always_comb begin
        trim = '0;
        for (int i = 0; i < TRIM_W; i++)
            trim[i] = (LVL_W'(i) < level);
    end

`ifdef PLL_FREQ_CONTROLLER_MEAS_EN
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= valid;
            if (valid)
                meas_count <= cnt;
        end
    end
`endif

endmodule
